// File: rtl/collect.sv
// collect: merges NUM_DATA_INPUTS lane streams into one output through a 2-entry FIFO; input accept -> data_out 1 cycle.
// Backpressure: avail_out drops when the FIFO holds 2 items; COLLECT_STATS_EN adds the stall_cycles counter.

module collect_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;
endmodule

module collect #(
  parameter int NUM_DATA_INPUTS        = 8,
  parameter int DATA_WIDTH             = 8,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  configure,
  input  logic                                  conf_mode,
  input  logic [LOG_MAX_ITERS-1:0]              num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0]     num_reads_per_iter,
  input  logic [NUM_DATA_INPUTS*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_DATA_INPUTS-1:0]            valid_in,
  output logic [NUM_DATA_INPUTS-1:0]            avail_out,
  output logic [DATA_WIDTH-1:0]                 data_out,
  output logic                                  valid_out,
  input  logic                                  avail_in,
  output logic                                  busy,
  output logic                                  done
`ifdef COLLECT_STATS_EN
  ,
  output logic [31:0]                           stall_cycles
`endif
);
  localparam int LW = $clog2(NUM_DATA_INPUTS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                            state_q, state_d;
  logic                              mode_q, mode_d;
  logic [LOG_MAX_ITERS-1:0]          iters_q, iters_d;
  logic [LOG_MAX_READS_PER_ITER-1:0] reads_q, reads_d;
  logic [LW-1:0]                     lane_q, lane_d;
  logic [LOG_MAX_READS_PER_ITER-1:0] read_q, read_d;
  logic [LOG_MAX_ITERS-1:0]          iter_q, iter_d;

  logic                  sel_rdy, accept, pop;
  logic                  last_lane, last_read, last_iter;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic [1:0]            fifo_count;

  assign sel_rdy   = (state_q == S_RUN) && (fifo_count < 2'd2);
  assign accept    = sel_rdy && valid_in[lane_q];
  assign avail_out = sel_rdy ? (NUM_DATA_INPUTS'(1) << lane_q) : '0;
  assign sel_dat   = data_in[lane_q*DATA_WIDTH +: DATA_WIDTH];
  assign valid_out = (fifo_count != 2'd0);
  assign pop       = valid_out && avail_in;
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);

  // Limits compared as count-1 so all-ones counts never need a wider counter.
  assign last_lane = (lane_q == LW'(NUM_DATA_INPUTS - 1));
  assign last_read = (read_q == reads_q - 1'b1);
  assign last_iter = (iter_q == iters_q - 1'b1);

  collect_fifo #(.W(DATA_WIDTH), .DEPTH(2)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .push_dat (sel_dat),
    .pop      (pop),
    .head_dat (data_out),
    .count    (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    iters_d = iters_q;
    reads_d = reads_q;
    lane_d  = lane_q;
    read_d  = read_q;
    iter_d  = iter_q;
    case (state_q)
      S_IDLE: begin
        if (configure) begin
          mode_d  = conf_mode;
          iters_d = num_iters;
          reads_d = num_reads_per_iter;
          lane_d  = '0;
          read_d  = '0;
          iter_d  = '0;
          state_d = (num_iters == '0 || num_reads_per_iter == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (!mode_q) begin
            // Block order: reads innermost, then lanes.
            if (last_read) begin
              read_d = '0;
              if (last_lane) begin
                lane_d = '0;
                iter_d = last_iter ? '0 : iter_q + 1'b1;
              end else begin
                lane_d = lane_q + 1'b1;
              end
            end else begin
              read_d = read_q + 1'b1;
            end
          end else begin
            // Round-robin order: lanes innermost, then read slots.
            if (last_lane) begin
              lane_d = '0;
              if (last_read) begin
                read_d = '0;
                iter_d = last_iter ? '0 : iter_q + 1'b1;
              end else begin
                read_d = read_q + 1'b1;
              end
            end else begin
              lane_d = lane_q + 1'b1;
            end
          end
          if (last_lane && last_read && last_iter) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fifo_count == 2'd0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      iters_q <= '0;
      reads_q <= '0;
      lane_q  <= '0;
      read_q  <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      iters_q <= iters_d;
      reads_q <= reads_d;
      lane_q  <= lane_d;
      read_q  <= read_d;
      iter_q  <= iter_d;
    end
  end

`ifdef COLLECT_STATS_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && configure) begin
      stall_d = '0;
    end else if (busy && valid_out && !avail_in && stall_q != 32'hFFFF_FFFF) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_collect.sv
// Randomized scoreboard bench for collect: lane producers, expected-order model, output monitor.
module tb_collect;
  localparam int NL = 8;
  localparam int DW = 8;
  localparam int LI = 16;
  localparam int LR = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              configure;
  logic              conf_mode;
  logic [LI-1:0]     num_iters;
  logic [LR-1:0]     num_reads_per_iter;
  logic [NL*DW-1:0]  data_in;
  logic [NL-1:0]     valid_in;
  logic [NL-1:0]     avail_out;
  logic [DW-1:0]     data_out;
  logic              valid_out;
  logic              avail_in;
  logic              busy;
  logic              done;
`ifdef COLLECT_STATS_EN
  logic [31:0]       stall_cycles;
`endif

  always #5 clk = ~clk;

  collect #(
    .NUM_DATA_INPUTS(NL), .DATA_WIDTH(DW),
    .LOG_MAX_ITERS(LI), .LOG_MAX_READS_PER_ITER(LR)
  ) dut (
    .clk(clk), .rst(rst), .configure(configure), .conf_mode(conf_mode),
    .num_iters(num_iters), .num_reads_per_iter(num_reads_per_iter),
    .data_in(data_in), .valid_in(valid_in), .avail_out(avail_out),
    .data_out(data_out), .valid_out(valid_out), .avail_in(avail_in),
    .busy(busy), .done(done)
`ifdef COLLECT_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] lane_dat [NL][64];
  int            lane_idx [NL];
  int            lane_len [NL];
  logic [DW-1:0] exp_q [$];
  int  in_cnt = 0, out_cnt = 0, done_cnt = 0, cyc = 0;
  int  out_first = -1, out_last = -1, job_done0 = 0, job_out0 = 0;
  bit  rand_valid = 1'b0, rand_avail = 1'b0, avail_force = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Lane producers: present the next item of each lane's sequence.
  always @(negedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (lane_idx[i] < lane_len[i]) begin
        valid_in[i] = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        data_in[i*DW +: DW] = lane_dat[i][lane_idx[i]];
      end else begin
        valid_in[i] = 1'b0;
        data_in[i*DW +: DW] = DW'($urandom);
      end
    end
    avail_in = rand_avail ? 1'($urandom_range(0, 1)) : avail_force;
    #2;
    for (int i = 0; i < NL; i++) begin
      if (valid_in[i] && avail_out[i]) begin
        lane_idx[i]++;
        in_cnt++;
      end
    end
  end

  // Output monitor: compares each transfer about to happen at the next edge.
  always @(negedge clk) begin
    #3;
    cyc++;
    chk("avail_onehot", 64'($countones(avail_out) <= 1), 64'd1);
    if (valid_out && avail_in) begin
      out_cnt++;
      if (out_first < 0) out_first = cyc;
      out_last = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0h required=none", data_out);
      end else begin
        chk("data_out", 64'(data_out), 64'(exp_q.pop_front()));
      end
    end
    chk("outstanding_le2", 64'((in_cnt - out_cnt) <= 2 && (in_cnt - out_cnt) >= 0), 64'd1);
    if (done) done_cnt++;
  end

  task automatic start_job(input bit mode, input int iters, input int reads, input bit pat);
    @(posedge clk);
    #1;
    for (int l = 0; l < NL; l++) begin
      lane_idx[l] = 0;
      lane_len[l] = iters * reads;
      for (int k = 0; k < 64; k++)
        lane_dat[l][k] = pat ? DW'(l * 16 + k) : DW'($urandom);
    end
    exp_q.delete();
    for (int it = 0; it < iters; it++) begin
      if (!mode) begin
        for (int l = 0; l < NL; l++)
          for (int r = 0; r < reads; r++) exp_q.push_back(lane_dat[l][it*reads + r]);
      end else begin
        for (int r = 0; r < reads; r++)
          for (int l = 0; l < NL; l++) exp_q.push_back(lane_dat[l][it*reads + r]);
      end
    end
    out_first = -1;
    out_last  = -1;
    job_done0 = done_cnt;
    job_out0  = out_cnt;
    @(negedge clk);
    #1;
    configure = 1'b1;
    conf_mode = mode;
    num_iters = LI'(iters);
    num_reads_per_iter = LR'(reads);
    @(negedge clk);
    #1;
    configure = 1'b0;
    conf_mode = 1'($urandom);
    num_iters = LI'($urandom);
    num_reads_per_iter = LR'($urandom);
  endtask

  task automatic wait_done(input string name, input int bound, input bit inject);
    int total;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      #1;
      configure = 1'b0;
      if (inject && k == 4) begin
        configure = 1'b1;
        conf_mode = ~conf_mode;
        num_iters = LI'(1);
        num_reads_per_iter = LR'(1);
      end
      #3;
      if (done_cnt != job_done0) break;
    end
    configure = 1'b0;
    chk({name, "_done_seen"}, 64'(done_cnt != job_done0), 64'd1);
    repeat (3) @(negedge clk);
    #4;
    chk({name, "_done_once"}, 64'(done_cnt - job_done0), 64'd1);
    chk({name, "_exp_empty"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_busy_low"}, 64'(busy), 64'd0);
    total = 0;
    for (int l = 0; l < NL; l++) total += lane_len[l] - lane_idx[l];
    chk({name, "_lanes_drained"}, 64'(total), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int l = 0; l < NL; l++) begin
      lane_idx[l] = 0;
      lane_len[l] = 0;
    end
    configure = 1'b0;
    conf_mode = 1'b0;
    num_iters = '0;
    num_reads_per_iter = '0;
    valid_in = '0;
    data_in = '0;
    avail_in = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_avail_out", 64'(avail_out), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    #1 rst = 1'b1;

    // Block order, full rate
    rand_valid = 1'b0; rand_avail = 1'b0; avail_force = 1'b1;
    start_job(1'b0, 2, 3, 1'b1);
    wait_done("block", 500, 1'b0);
    chk("block_count", 64'(out_cnt - job_out0), 64'd48);
    chk("block_rate", 64'(out_last - out_first), 64'd47);

    // Round-robin order
    start_job(1'b1, 1, 2, 1'b1);
    wait_done("rr", 500, 1'b0);
    chk("rr_count", 64'(out_cnt - job_out0), 64'd16);

    // Zero counts complete immediately with no traffic
    for (int z = 0; z < 2; z++) begin
      start_job(1'b0, (z == 0) ? 0 : 2, (z == 0) ? 3 : 0, 1'b1);
      #3;
      chk("zero_done", 64'(done), 64'd1);
      chk("zero_busy", 64'(busy), 64'd0);
      chk("zero_avail_out", 64'(avail_out), 64'd0);
      chk("zero_valid_out", 64'(valid_out), 64'd0);
      @(negedge clk);
      #4;
      chk("zero_done_pulse", 64'(done), 64'd0);
      chk("zero_done_once", 64'(done_cnt - job_done0), 64'd1);
    end

    // Random valid/avail, random configs, configure injected mid-job
    rand_valid = 1'b1; rand_avail = 1'b1;
    for (int j = 0; j < 8; j++) begin
      start_job(1'($urandom), $urandom_range(1, 3), $urandom_range(1, 4), 1'b0);
      wait_done("random", 3000, 1'b1);
    end

    // Reset mid-job with a full FIFO
    rand_valid = 1'b0; rand_avail = 1'b0; avail_force = 1'b0;
    start_job(1'b0, 2, 3, 1'b1);
    repeat (6) @(negedge clk);
    #4;
    chk("full_avail_out", 64'(avail_out), 64'd0);
    chk("full_valid_out", 64'(valid_out), 64'd1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    for (int l = 0; l < NL; l++) lane_len[l] = 0;
    in_cnt = 0;
    out_cnt = 0;
    @(negedge clk);
    #4;
    chk("midrst_valid_out", 64'(valid_out), 64'd0);
    chk("midrst_avail_out", 64'(avail_out), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    avail_force = 1'b1;
    start_job(1'b1, 2, 2, 1'b0);
    wait_done("post_rst", 500, 1'b0);

`ifdef COLLECT_STATS_EN
    avail_force = 1'b0;
    start_job(1'b0, 1, 2, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #4;
      if (valid_out) break;
    end
    chk("stall_start", 64'(stall_cycles), 64'd0);
    repeat (10) @(negedge clk);
    #4;
    chk("stall_ten", 64'(stall_cycles), 64'd10);
    avail_force = 1'b1;
    wait_done("stall_job", 500, 1'b0);
    start_job(1'b0, 1, 1, 1'b1);
    chk("stall_clear", 64'(stall_cycles), 64'd0);
    wait_done("stall_job2", 500, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
